axi_dma_rd_master: RTL and testbench

// - AXI4 read initiator: fetches a contiguous block of words (e.g. NN weights) from an AXI4 RAM slave.
// - Delivers the words in order on a valid/ready output stream to the coprocessor datapath.
// - One command describes the whole transfer. The block splits it into INCR bursts that respect
//   MAX_BURST_LEN and 4 KB boundaries, with one burst outstanding at a time.

---
 rtl/axi_dma_rd_master_pkg.sv | 22 ++
 rtl/axi_dma_rd_master_if.sv | 45 ++++
 rtl/axi_dma_rd_master.sv | 201 ++++++++++++++++++++
 tb/tb_axi_dma_rd_master.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_rd_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_dma_rd_master_pkg
// Description : Shared AXI constants and the read-master FSM state encoding.
// Contents    : AXI_BURST_INCR, AXI_RESP_OKAY, AXI_BOUNDARY, rd_state_t
// Revision    : 1.0 - initial release
// ============================================================================
package axi_dma_rd_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_BOUNDARY   = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_dma_rd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_dma_rd_master_if
// Description : AXI4 read address / read data channels.
// Modports    : master - the read initiator (drives AR, rready)
//               slave  - the memory side (drives arready, R)
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_dma_rd_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_dma_rd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_dma_rd_master
// Description : AXI4 read initiator. One command fetches cmd_len contiguous
//               words starting at cmd_addr, split into INCR bursts limited by
//               MAX_BURST_LEN and 4 KB boundaries, one burst outstanding.
//               Words leave in order on a registered valid/ready stream.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               cmd_addr/len/valid/ready - transfer command
//               busy, done, err          - status (err sticky until next accept)
//               m_axi                    - AXI4 AR/R channels (master modport)
//               m_axis_tdata/tlast/tvalid/tready - output word stream
// Revision    : 1.0 - initial release
// ============================================================================
module axi_dma_rd_master
    import axi_dma_rd_master_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int ARID_VALUE    = 0,
    parameter int MAX_BURST_LEN = 16,
    parameter int LEN_WIDTH     = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [ADDR_WIDTH-1:0] cmd_addr,
    input  wire logic [LEN_WIDTH-1:0]  cmd_len,
    input  wire logic                  cmd_valid,
    output logic                       cmd_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    axi_dma_rd_master_if.master        m_axi,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  wire logic                  m_axis_tready
);

    localparam int                    SIZE     = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] STRB_INC = ADDR_WIDTH'(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0]   ARID_C   = ID_WIDTH'(ARID_VALUE);

    // Beats in the next burst: limited by words left, the burst cap and the
    // words remaining before the next 4 KB page.
    function automatic logic [8:0] calc_beats(input logic [ADDR_WIDTH-1:0] a,
                                              input logic [LEN_WIDTH-1:0]  rem);
        logic [12:0] room;
        logic [31:0] lim;
        room = 13'(AXI_BOUNDARY) - {1'b0, a[11:0]};
        room = room >> SIZE;
        lim  = 32'(rem);
        if (lim > 32'(MAX_BURST_LEN)) lim = 32'(MAX_BURST_LEN);
        if (lim > 32'(room))          lim = 32'(room);
        return lim[8:0];
    endfunction

    rd_state_t             state;
    rd_state_t             state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [8:0]            beat_cnt;
    logic [8:0]            burst_beats;
    logic [8:0]            beats_m1;
    logic                  ar_valid;
    logic                  rd_ready;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  t_fire;
    logic                  beat_bad;

    // AR fields come straight from addr/remaining, which do not move while
    // the request waits in ST_ADDR, so they stay stable until arready.
    assign burst_beats = calc_beats(addr, remaining);
    assign beats_m1    = burst_beats - 9'd1;

    assign m_axi.arid    = ARID_C;
    assign m_axi.araddr  = addr;
    assign m_axi.arlen   = beats_m1[7:0];
    assign m_axi.arsize  = 3'(SIZE);
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = ar_valid;
    assign m_axi.rready  = rd_ready;

    assign ar_fire = ar_valid && m_axi.arready;
    assign r_fire  = m_axi.rvalid && rd_ready;
    assign t_fire  = m_axis_tvalid && m_axis_tready;

    assign beat_bad = (m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rid != ARID_C) ||
                      (m_axi.rlast != (beat_cnt == 9'd1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rd_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_len != '0)) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (ar_fire) state_next = ST_DATA;
            end
            ST_DATA: begin
                // Accept a beat only when the output register is free or
                // emptying this cycle.
                rd_ready = !m_axis_tvalid || m_axis_tready;
                if (m_axi.rvalid && rd_ready && (beat_cnt == 9'd1))
                    state_next = (remaining == LEN_ONE) ? ST_DRAIN : ST_ADDR;
            end
            ST_DRAIN: begin
                if (t_fire && m_axis_tlast) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            ar_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        err <= 1'b0;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr      <= cmd_addr & ~LOW_MASK;
                            remaining <= cmd_len;
                            busy      <= 1'b1;
                            ar_valid  <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (ar_fire) begin
                        ar_valid <= 1'b0;
                        beat_cnt <= burst_beats;
                    end
                end
                ST_DATA: begin
                    if (r_fire) begin
                        addr      <= addr + STRB_INC;
                        remaining <= remaining - LEN_ONE;
                        beat_cnt  <= beat_cnt - 9'd1;
                        // Raise the next request together with the final beat
                        // so it is on the bus the following cycle.
                        if ((beat_cnt == 9'd1) && (remaining != LEN_ONE))
                            ar_valid <= 1'b1;
                        if (beat_bad) err <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (t_fire && m_axis_tlast) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single output register stage; words are forwarded even on error.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (r_fire) begin
            m_axis_tdata  <= m_axi.rdata;
            m_axis_tlast  <= (remaining == LEN_ONE);
            m_axis_tvalid <= 1'b1;
        end else if (t_fire) begin
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_rd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_dma_rd_master
// Description : Scoreboard bench for axi_dma_rd_master with a behavioural
//               AXI4 RAM slave (32-bit, mem[i]=i).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_dma_rd_master;

    typedef struct { logic [15:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [31:0] data; logic last; } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready, busy, done, err;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast, m_axis_tvalid;
    logic        m_axis_tready = 1'b1;

    axi_dma_rd_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .ID_WIDTH(8)) bus ();

    axi_dma_rd_master dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .busy(busy), .done(done), .err(err),
        .m_axi(bus),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    failed = 0;
    ar_t   ar_exp[$];
    word_t sb[$];
    ar_t   slave_q[$];
    logic  r_fire = 1'b0;
    int    tmode = 0;
    int    inj_beat = -1;
    int    beat_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            word_t w;
            w.data = 32'(first + i);
            w.last = (i == n - 1);
            sb.push_back(w);
        end
    endtask

    task automatic push_ar(input logic [15:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        ar_exp.push_back(e);
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] n);
        int k;
        @(posedge clk); #1;
        cmd_addr = a; cmd_len = n; cmd_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
        if (!cmd_ready) begin
            tests++; failed++;
            $display("FAIL cmd_accept: got timeout expected cmd_ready");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        bit seen;
        seen = 0;
        k = 0;
        while (!seen && k < budget) begin
            @(negedge clk);
            if (done) seen = 1;
            k++;
        end
        tests++;
        if (!seen) begin
            failed++;
            $display("FAIL %s_done: got no done pulse expected done within %0d cycles", name, budget);
        end
        check({name, "_words_left"}, 32'(sb.size()), 32'd0);
        check({name, "_ars_left"}, 32'(ar_exp.size()), 32'd0);
    endtask

    // Behavioural AXI4 RAM slave: mem[i] = i, one beat offered at a time.
    initial begin
        int   beats_left;
        logic [15:0] s_addr;
        ar_t  b;
        beats_left = 0;
        s_addr = '0;
        bus.arready = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0;
        bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rid = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
                beats_left = 0;
                slave_q.delete();
            end else begin
                if (bus.rvalid && r_fire) begin
                    bus.rvalid = 1'b0; bus.rlast = 1'b0;
                    beats_left--;
                    s_addr = s_addr + 16'd4;
                end
                if (!bus.rvalid) begin
                    if (beats_left == 0 && slave_q.size() > 0) begin
                        b = slave_q.pop_front();
                        s_addr = b.addr;
                        beats_left = int'(b.len) + 1;
                    end
                    if (beats_left > 0) begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = 32'(s_addr >> 2);
                        bus.rlast  = (beats_left == 1);
                        bus.rresp  = (beat_no == inj_beat) ? 2'b10 : 2'b00;
                        beat_no++;
                    end
                end
            end
            bus.arready = (tmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Output consumer: always ready, or random with periodic 3-cycle stalls.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk); #1;
            if (tmode == 0) m_axis_tready = 1'b1;
            else begin
                cyc++;
                if ((cyc % 20) >= 17) m_axis_tready = 1'b0;
                else                  m_axis_tready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: AR and stream scoreboards, stall stability, sticky err model.
    initial begin
        logic        exp_err, t_stall, ar_stall, prev_last;
        logic [31:0] prev_data;
        logic [15:0] prev_araddr;
        logic [7:0]  prev_arlen;
        ar_t   e, c;
        word_t w;
        exp_err = 0; t_stall = 0; ar_stall = 0; prev_last = 0;
        prev_data = '0; prev_araddr = '0; prev_arlen = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_err = 0; t_stall = 0; ar_stall = 0; r_fire = 1'b0;
            end else begin
                check("err_sticky", 32'(err), 32'(exp_err));
                r_fire = bus.rvalid && bus.rready;
                if (cmd_valid && cmd_ready)              exp_err = 0;
                else if (r_fire && bus.rresp != 2'b00)   exp_err = 1;

                if (ar_stall) begin
                    check("ar_hold_valid", 32'(bus.arvalid), 32'd1);
                    check("ar_hold_addr", 32'(bus.araddr), 32'(prev_araddr));
                    check("ar_hold_len", 32'(bus.arlen), 32'(prev_arlen));
                end
                if (bus.arvalid && bus.arready) begin
                    if (ar_exp.size() == 0) begin
                        tests++; failed++;
                        $display("FAIL ar_unexpected: got AR addr 0x%0h expected none", bus.araddr);
                    end else begin
                        e = ar_exp.pop_front();
                        check("araddr", 32'(bus.araddr), 32'(e.addr));
                        check("arlen", 32'(bus.arlen), 32'(e.len));
                    end
                    check("arsize", 32'(bus.arsize), 32'd2);
                    check("arburst", 32'(bus.arburst), 32'd1);
                    check("arid", 32'(bus.arid), 32'd0);
                    c.addr = bus.araddr;
                    c.len  = bus.arlen;
                    slave_q.push_back(c);
                end
                ar_stall = bus.arvalid && !bus.arready;
                prev_araddr = bus.araddr;
                prev_arlen  = bus.arlen;

                if (t_stall) begin
                    check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
                    check("stall_tdata", m_axis_tdata, prev_data);
                    check("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
                end
                if (m_axis_tvalid && !m_axis_tready)
                    check("rready_backpressure", 32'(bus.rready), 32'd0);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb.size() == 0) begin
                        tests++; failed++;
                        $display("FAIL stream_unexpected: got word 0x%0h expected none", m_axis_tdata);
                    end else begin
                        w = sb.pop_front();
                        check("tdata", m_axis_tdata, w.data);
                        check("tlast", 32'(m_axis_tlast), 32'(w.last));
                    end
                end
                t_stall   = m_axis_tvalid && !m_axis_tready;
                prev_data = m_axis_tdata;
                prev_last = m_axis_tlast;
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({name, "_arvalid"}, 32'(bus.arvalid), 32'd0);
        check({name, "_rready"}, 32'(bus.rready), 32'd0);
        check({name, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({name, "_tlast"}, 32'(m_axis_tlast), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: single burst
        push_ar(16'h0100, 8'd3);
        push_words(32'h40, 4);
        send_cmd(16'h0100, 16'd4);
        @(negedge clk);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 200);

        // T2: split by burst cap
        push_ar(16'h0000, 8'd15);
        push_ar(16'h0040, 8'd15);
        push_ar(16'h0080, 8'd7);
        push_words(0, 40);
        send_cmd(16'h0000, 16'd40);
        wait_done("t2", 400);

        // T3: 4 KB crossing
        push_ar(16'h0FF8, 8'd1);
        push_ar(16'h1000, 8'd1);
        push_words(32'h3FE, 4);
        send_cmd(16'h0FF8, 16'd4);
        wait_done("t3", 200);

        // T4: T2 under backpressure
        tmode = 1;
        push_ar(16'h0000, 8'd15);
        push_ar(16'h0040, 8'd15);
        push_ar(16'h0080, 8'd7);
        push_words(0, 40);
        send_cmd(16'h0000, 16'd40);
        wait_done("t4", 2000);
        tmode = 0;

        // T5: error response on the second beat
        beat_no = 0;
        inj_beat = 1;
        push_ar(16'h0200, 8'd3);
        push_words(32'h80, 4);
        send_cmd(16'h0200, 16'd4);
        wait_done("t5", 200);
        check("t5_err_after", 32'(err), 32'd1);
        inj_beat = -1;

        // T6: reset mid-transfer, zero length, then a normal command
        push_ar(16'h0000, 8'd15);
        push_ar(16'h0040, 8'd15);
        push_ar(16'h0080, 8'd7);
        push_words(0, 40);
        send_cmd(16'h0000, 16'd40);
        @(negedge clk);
        check("t6_err_cleared", 32'(err), 32'd0);
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t6_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        ar_exp.delete();
        repeat (5) @(negedge clk);

        send_cmd(16'h0300, 16'd0);
        wait_done("t6_len0", 5);

        push_ar(16'h0104, 8'd3);
        push_words(32'h41, 4);
        send_cmd(16'h0104, 16'd4);
        wait_done("t6_len4", 200);
        check("t6_err_final", 32'(err), 32'd0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
